lcd_status_composer: RTL

- Upstream feeder of the 20x2 character LCD driver. Produces its two 160-bit ASCII row buffers (row_1, row_2).
- Row 1 is a live game status line: countdown timer, strike count and outcome.
- Row 2 is a 20-char message line written byte-by-byte by game modules through a valid/ready port.
- Byte 0 (leftmost char) of each row is bits [159:152]; byte 19 is [7:0].

---
 rtl/lcd_status_composer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_status_composer.sv
// lcd_status_composer: builds the two 20-character ASCII rows for the LCD driver.
// Row 1 shows the game countdown, the strike count and the outcome.
// Row 2 is a free message line fed one character at a time by the game modules.
module lcd_status_composer #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int START_SEC   = 300,
   parameter int MAX_STRIKES = 3
) (
   input  logic         CLK,
   input  logic         _RST,
   input  logic         start,
   input  logic         strike,
   input  logic         defused,
   input  logic         msg_valid,
   input  logic [7:0]   msg_char,
   output logic         msg_ready,
   input  logic         msg_clr,
   output logic [159:0] row_1,
   output logic [159:0] row_2,
   output logic         running,
   output logic         exploded,
   output logic [12:0]  sec_left
);

   localparam int             PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRESC_MAX   = PW'(CLK_HZ - 1);
   localparam int             START_MM    = START_SEC / 60;
   localparam int             START_SS    = START_SEC % 60;
   localparam logic [3:0]     INIT_MTENS  = 4'(START_MM / 10);
   localparam logic [3:0]     INIT_MONES  = 4'(START_MM % 10);
   localparam logic [3:0]     INIT_STENS  = 4'(START_SS / 10);
   localparam logic [3:0]     INIT_SONES  = 4'(START_SS % 10);
   localparam logic [12:0]    INIT_SEC    = 13'(START_SEC);
   localparam logic [3:0]     STRIKE_LAST = 4'(MAX_STRIKES - 1);
   localparam logic [159:0]   BLANK_ROW   = {20{8'h20}};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BOOM, ST_DONE} gameState_t;
   typedef enum logic {CLR_IDLE, CLR_BUSY} clrState_t;

   gameState_t     r_state;
   gameState_t     w_nextState;
   clrState_t      r_clrState;
   clrState_t      w_clrNext;

   logic [PW-1:0]  r_presc;
   logic [3:0]     r_mTens;
   logic [3:0]     r_mOnes;
   logic [3:0]     r_sTens;
   logic [3:0]     r_sOnes;
   logic [12:0]    r_secLeft;
   logic [3:0]     r_strikes;
   logic [159:0]   r_row2;
   logic [4:0]     r_cursor;
   logic [4:0]     r_clrIdx;

   logic           w_tick;
   logic           w_lastSecond;
   logic           w_reload;
   logic           w_decrement;
   logic           w_addStrike;
   logic           w_transfer;
   logic [159:0]   w_row1;

   assign w_tick       = (r_state == ST_RUN) && (r_presc == PRESC_MAX);
   assign w_lastSecond = (r_mTens == 4'd0) && (r_mOnes == 4'd0) &&
                         (r_sTens == 4'd0) && (r_sOnes == 4'd1);

   // Game state register.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Game next-state and per-cycle control: detonation beats defusal beats a plain strike.
   always_comb begin
      w_nextState = r_state;
      w_reload    = 1'b0;
      w_decrement = 1'b0;
      w_addStrike = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_nextState = ST_RUN;
               w_reload    = 1'b1;
            end
         end
         ST_RUN: begin
            w_decrement = w_tick;
            w_addStrike = strike;
            if ((w_tick && w_lastSecond) || (strike && (r_strikes == STRIKE_LAST))) begin
               w_nextState = ST_BOOM;
            end else if (defused) begin
               w_nextState = ST_DONE;
            end
         end
         ST_BOOM, ST_DONE: begin
            if (start) begin
               w_nextState = ST_RUN;
               w_reload    = 1'b1;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // One-second prescaler, only free-running while staying in RUN.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_presc <= '0;
      end else if ((r_state == ST_RUN) && (w_nextState == ST_RUN)) begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end else begin
         r_presc <= '0;
      end
   end

   // BCD mm:ss countdown with a binary seconds counter kept in lockstep.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_mTens   <= INIT_MTENS;
         r_mOnes   <= INIT_MONES;
         r_sTens   <= INIT_STENS;
         r_sOnes   <= INIT_SONES;
         r_secLeft <= INIT_SEC;
      end else if (w_reload) begin
         r_mTens   <= INIT_MTENS;
         r_mOnes   <= INIT_MONES;
         r_sTens   <= INIT_STENS;
         r_sOnes   <= INIT_SONES;
         r_secLeft <= INIT_SEC;
      end else if (w_decrement) begin
         r_secLeft <= r_secLeft - 13'd1;
         if (r_sOnes != 4'd0) begin
            r_sOnes <= r_sOnes - 4'd1;
         end else begin
            r_sOnes <= 4'd9;
            if (r_sTens != 4'd0) begin
               r_sTens <= r_sTens - 4'd1;
            end else begin
               r_sTens <= 4'd5;
               if (r_mOnes != 4'd0) begin
                  r_mOnes <= r_mOnes - 4'd1;
               end else begin
                  r_mOnes <= 4'd9;
                  r_mTens <= r_mTens - 4'd1;
               end
            end
         end
      end
   end

   // Strike counter; the fatal strike is still counted.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_strikes <= 4'd0;
      end else if (w_reload) begin
         r_strikes <= 4'd0;
      end else if (w_addStrike) begin
         r_strikes <= r_strikes + 4'd1;
      end
   end

   // Status line assembled from registered state.
   always_comb begin
      w_row1          = BLANK_ROW;
      w_row1[159:120] = "TIME ";
      w_row1[119:112] = 8'h30 + {4'h0, r_mTens};
      w_row1[111:104] = 8'h30 + {4'h0, r_mOnes};
      w_row1[103:96]  = ":";
      w_row1[95:88]   = 8'h30 + {4'h0, r_sTens};
      w_row1[87:80]   = 8'h30 + {4'h0, r_sOnes};
      w_row1[79:64]   = "  ";
      case (r_state)
         ST_BOOM: w_row1[63:0] = "BOOM!   ";
         ST_DONE: w_row1[63:0] = "DEFUSED!";
         default: w_row1[63:0] = {"STRIKE ", 8'h30 + {4'h0, r_strikes}};
      endcase
   end

   // Clear sequencer state register.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_clrState <= CLR_IDLE;
      end else begin
         r_clrState <= w_clrNext;
      end
   end

   // Clear sequencer next state: a clear runs once over all 20 bytes.
   always_comb begin
      w_clrNext = r_clrState;
      case (r_clrState)
         CLR_IDLE: begin
            if (msg_clr) begin
               w_clrNext = CLR_BUSY;
            end
         end
         CLR_BUSY: begin
            if (r_clrIdx == 5'd19) begin
               w_clrNext = CLR_IDLE;
            end
         end
         default: begin
            w_clrNext = CLR_IDLE;
         end
      endcase
   end

   // Clear index: starts at byte 0 on the request, steps once per busy cycle.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_clrIdx <= 5'd0;
      end else if (r_clrState == CLR_IDLE) begin
         r_clrIdx <= 5'd0;
      end else begin
         r_clrIdx <= r_clrIdx + 5'd1;
      end
   end

   assign msg_ready  = (r_clrState == CLR_IDLE) && !msg_clr;
   assign w_transfer = msg_valid && msg_ready;

   // Message row storage: clear writes and host writes never overlap since ready is low while busy.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_row2 <= BLANK_ROW;
      end else if (r_clrState == CLR_BUSY) begin
         for (int b = 0; b < 20; b++) begin
            if (r_clrIdx == 5'(b)) begin
               r_row2[159-8*b -: 8] <= 8'h20;
            end
         end
      end else if (w_transfer && (msg_char != 8'h0A)) begin
         for (int b = 0; b < 20; b++) begin
            if (r_cursor == 5'(b)) begin
               r_row2[159-8*b -: 8] <= msg_char;
            end
         end
      end
   end

   // Cursor: newline homes it, other chars advance with wrap, a finished clear homes it.
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         r_cursor <= 5'd0;
      end else if ((r_clrState == CLR_BUSY) && (r_clrIdx == 5'd19)) begin
         r_cursor <= 5'd0;
      end else if (w_transfer) begin
         if ((msg_char == 8'h0A) || (r_cursor == 5'd19)) begin
            r_cursor <= 5'd0;
         end else begin
            r_cursor <= r_cursor + 5'd1;
         end
      end
   end

   assign row_1    = w_row1;
   assign row_2    = r_row2;
   assign running  = (r_state == ST_RUN);
   assign exploded = (r_state == ST_BOOM);
   assign sec_left = r_secLeft;

endmodule
